nw_traceback: RTL and testbench

- Reader side of the score/arrow matrix. The fill stage writes one 3-bit arrow symbol per cell into the arrow RAM.
- This block walks that RAM backwards from cell (len_i, len_j) to (0,0). On each step it emits one alignment operation through a valid/ready stream to the aligned-string builder.
- It sits between the arrow RAM read port and the output formatter.

---
 rtl/nw_traceback.sv | 151 +++++++++++++++
 tb/tb_nw_traceback.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nw_traceback.sv
// Needleman-Wunsch traceback: walks the arrow RAM from (len_i, len_j) back to (0,0) and
// emits one alignment move per step over a valid/ready stream.
module nw_traceback #(
  parameter int unsigned IDX_W      = 7,
  parameter logic [2:0]  arrow_lx   = 3'b100,
  parameter logic [2:0]  arrow_up   = 3'b010,
  parameter logic [2:0]  arrow_diag = 3'b001
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [IDX_W-1:0]   len_i,
  input  logic [IDX_W-1:0]   len_j,
  output logic [2*IDX_W-1:0] ram_addr,
  output logic               ram_rd,
  input  logic [2:0]         ram_data,
  output logic               step_valid,
  input  logic               step_ready,
  output logic [2:0]         step_op,
  output logic [IDX_W-1:0]   step_i,
  output logic [IDX_W-1:0]   step_j,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {StIdle, StCheck, StRead, StWait, StEmit, StDone} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   i_q, i_d, j_q, j_d;
  logic [2*IDX_W-1:0] addr_q, addr_d;
  logic               rd_q, rd_d;
  logic               valid_q, valid_d;
  logic [2:0]         op_q, op_d;
  logic [IDX_W-1:0]   si_q, si_d, sj_q, sj_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               sym_ok;

  // Exactly one of the three move codes is acceptable.
  assign sym_ok = (ram_data == arrow_diag) || (ram_data == arrow_up) || (ram_data == arrow_lx);

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    valid_d = valid_q;
    op_d    = op_q;
    si_d    = si_q;
    sj_d    = sj_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          i_d     = len_i;
          j_d     = len_j;
          done_d  = 1'b0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (i_q == '0 && j_q == '0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StDone;
        end else if (i_q == '0 || j_q == '0) begin
          // Edge of the matrix: the move is forced, no RAM access needed.
          op_d    = (i_q == '0) ? arrow_lx : arrow_up;
          si_d    = i_q;
          sj_d    = j_q;
          valid_d = 1'b1;
          state_d = StEmit;
        end else begin
          addr_d  = {i_q, j_q};
          rd_d    = 1'b1;
          state_d = StRead;
        end
      end
      StRead: state_d = StWait;
      StWait: begin
        op_d = ram_data;
        if (sym_ok) begin
          si_d    = i_q;
          sj_d    = j_q;
          valid_d = 1'b1;
          state_d = StEmit;
        end else begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StDone;
        end
      end
      StEmit: begin
        if (step_ready) begin
          valid_d = 1'b0;
          if (op_q == arrow_diag || op_q == arrow_up) i_d = i_q - 1'b1;
          if (op_q == arrow_diag || op_q == arrow_lx) j_d = j_q - 1'b1;
          state_d = StCheck;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      op_q    <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
      op_q    <= op_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign ram_addr   = addr_q;
  assign ram_rd     = rd_q;
  assign step_valid = valid_q;
  assign step_op    = op_q;
  assign step_i     = si_q;
  assign step_j     = sj_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_nw_traceback.sv
// Directed bench for nw_traceback: behavioural arrow RAM, step/read monitors and
// hand-computed expectations checked with immediate assertions.
module tb_nw_traceback;

  localparam int unsigned IDX_W = 7;
  localparam logic [2:0] LX = 3'b100, UP = 3'b010, DG = 3'b001;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic [IDX_W-1:0]   len_i = '0, len_j = '0;
  logic [2*IDX_W-1:0] ram_addr;
  logic               ram_rd;
  logic [2:0]         ram_data = '0;
  logic               step_valid;
  logic               step_ready = 1'b1;
  logic [2:0]         step_op;
  logic [IDX_W-1:0]   step_i, step_j;
  logic               busy, done, err;

  logic [2:0]         mem [0:(1<<(2*IDX_W))-1];
  logic [2*IDX_W-1:0] addr_log [$];
  int                 rd_count = 0;
  int                 n_steps = 0;
  int                 n_checks = 0;
  int                 n_fail = 0;
  int                 base_rd, base_st, lat;
  logic [2:0]         f_op;
  logic [IDX_W-1:0]   f_i, f_j;

  nw_traceback #(.IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len_i      (len_i),
    .len_j      (len_j),
    .ram_addr   (ram_addr),
    .ram_rd     (ram_rd),
    .ram_data   (ram_data),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .step_op    (step_op),
    .step_i     (step_i),
    .step_j     (step_j),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ram_rd) ram_data <= mem[ram_addr];

  always @(negedge clk) begin
    if (ram_rd) begin
      rd_count <= rd_count + 1;
      addr_log.push_back(ram_addr);
    end
  end

  always @(posedge clk) if (rst && step_valid && step_ready) n_steps <= n_steps + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [2:0] sym);
    for (int a = 0; a < (1 << (2 * IDX_W)); a++) mem[a] = sym;
  endtask

  // Leaves the DUT in CHECK at the sample point.
  task automatic kick(input int li, input int lj);
    start = 1'b1;
    len_i = IDX_W'(li);
    len_j = IDX_W'(lj);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for step_valid, returns cycles waited; checks the step fields.
  task automatic expect_step(input string tag, input logic [2:0] op, input int si, input int sj,
                             output int cyc);
    cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (step_valid) begin
        cyc = k;
        break;
      end
    end
    check({tag, " valid"}, {31'd0, step_valid}, 32'd1);
    check({tag, " op"}, {29'd0, step_op}, {29'd0, op});
    check({tag, " i"}, {25'd0, step_i}, si);
    check({tag, " j"}, {25'd0, step_j}, sj);
  endtask

  task automatic expect_done(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (done) break;
      @(posedge clk); #1;
    end
    check({tag, " done"}, {31'd0, done}, 32'd1);
    check({tag, " busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    fill(DG);
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst valid", {31'd0, step_valid}, 32'd0);
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst addr", {18'd0, ram_addr}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Pure diagonal 3x3
    base_rd = rd_count;
    base_st = n_steps;
    kick(3, 3);
    check("diag busy", {31'd0, busy}, 32'd1);
    expect_step("diag s1", DG, 3, 3, lat);
    check("diag s1 latency", lat, 32'd3);
    expect_step("diag s2", DG, 2, 2, lat);
    check("diag s2 latency", lat, 32'd4);
    expect_step("diag s3", DG, 1, 1, lat);
    expect_done("diag");
    check("diag rd count", rd_count - base_rd, 32'd3);
    check("diag addr0", {18'd0, addr_log[base_rd]}, 32'h183);
    check("diag addr1", {18'd0, addr_log[base_rd+1]}, 32'h102);
    check("diag addr2", {18'd0, addr_log[base_rd+2]}, 32'h081);
    check("diag steps", n_steps - base_st, 32'd3);

    // Boundary walk 2x3
    fill(DG);
    mem[{7'd2, 7'd3}] = UP;
    base_rd = rd_count;
    base_st = n_steps;
    kick(2, 3);
    expect_step("bnd s1", UP, 2, 3, lat);
    expect_step("bnd s2", DG, 1, 3, lat);
    expect_step("bnd s3", LX, 0, 2, lat);
    check("bnd s3 latency", lat, 32'd2);
    expect_step("bnd s4", LX, 0, 1, lat);
    expect_done("bnd");
    check("bnd rd count", rd_count - base_rd, 32'd2);
    check("bnd steps", n_steps - base_st, 32'd4);

    // Backpressure on the first EMIT
    fill(DG);
    step_ready = 1'b0;
    base_rd = rd_count;
    base_st = n_steps;
    kick(2, 2);
    expect_step("bp s1", DG, 2, 2, lat);
    f_op = step_op;
    f_i  = step_i;
    f_j  = step_j;
    repeat (5) begin
      @(posedge clk); #1;
      check("bp hold valid", {31'd0, step_valid}, 32'd1);
    end
    check("bp frozen", {15'd0, step_op, step_i, step_j}, {15'd0, DG, 7'd2, 7'd2});
    check("bp frozen vs first", {15'd0, step_op, step_i, step_j}, {15'd0, f_op, f_i, f_j});
    check("bp no extra rd", rd_count - base_rd, 32'd1);
    check("bp no step yet", n_steps - base_st, 32'd0);
    step_ready = 1'b1;
    expect_step("bp s2", DG, 1, 1, lat);
    expect_done("bp");
    check("bp steps", n_steps - base_st, 32'd2);

    // Invalid symbol
    fill(DG);
    mem[{7'd3, 7'd3}] = 3'b011;
    base_st = n_steps;
    kick(3, 3);
    expect_done("inv");
    check("inv err", {31'd0, err}, 32'd1);
    check("inv steps", n_steps - base_st, 32'd0);

    // Zero-length start also clears err
    base_rd = rd_count;
    base_st = n_steps;
    kick(0, 0);
    check("zero err clr", {31'd0, err}, 32'd0);
    expect_done("zero");
    check("zero rd", rd_count - base_rd, 32'd0);
    check("zero steps", n_steps - base_st, 32'd0);

    // Start while busy is ignored
    fill(DG);
    base_st = n_steps;
    kick(2, 2);
    expect_step("sb s1", DG, 2, 2, lat);
    start = 1'b1;
    len_i = 7'd1;
    len_j = 7'd3;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    expect_step("sb s2", DG, 1, 1, lat);
    expect_done("sb");
    check("sb steps", n_steps - base_st, 32'd2);

    // Reset mid-EMIT
    step_ready = 1'b0;
    kick(3, 3);
    expect_step("mr s1", DG, 3, 3, lat);
    #2 rst = 1'b0;
    #1;
    check("mr valid", {31'd0, step_valid}, 32'd0);
    check("mr busy", {31'd0, busy}, 32'd0);
    check("mr done", {31'd0, done}, 32'd0);
    check("mr op", {29'd0, step_op}, 32'd0);
    check("mr ij", {18'd0, step_i, step_j}, 32'd0);
    check("mr rd", {31'd0, ram_rd}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step_ready = 1'b1;
    @(posedge clk); #1;
    check("mr idle", {30'd0, busy, done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
